// File: rtl/freq_est.sv
// freq_est -- gated rising-edge counter that estimates an NCO phase increment.
//
// A measurement window of 2^GATE_LOG2 clocks is opened by a start pulse. The
// number of rising edges of sig_in seen inside the window is the fraction of
// a full accumulator wrap per window. Shifting it left by
// ACC_WIDTH-GATE_LOG2 therefore gives the per-clock phase increment.
//
// Parameters
//   ACC_WIDTH  width of the estimated phase-increment word
//   GATE_LOG2  window length is 2^GATE_LOG2 clocks (2..ACC_WIDTH)
//
// Ports
//   clk      clock, rising edge
//   reset    synchronous, active-high reset
//   sig_in   signal under measurement
//   start    one-cycle request to open a window
//   abort    cancel an open window (no result produced)
//   ack      consumer acknowledge of the held result
//   busy     window open (state MEASURE)
//   valid    result held (state DONE)
//   edges    rising-edge count of the last completed window
//   inc_est  estimated phase increment of the last completed window
//
// Build option
//   FREQ_EST_SYNC_EN  when defined, sig_in passes through a two-flop
//                     synchronizer (asynchronous input). Otherwise sig_in
//                     must be synchronous to clk and gets one register stage.
module freq_est #(
  parameter int ACC_WIDTH = 24,
  parameter int GATE_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ack,
  output logic                 busy,
  output logic                 valid,
  output logic [GATE_LOG2-1:0] edges,
  output logic [ACC_WIDTH-1:0] inc_est
);

  localparam int SH = ACC_WIDTH - GATE_LOG2;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t               state, state_nxt;
  logic [GATE_LOG2-1:0] win_cnt;
  logic [GATE_LOG2-1:0] edge_cnt, edge_nxt;
  logic                 s_q, s_d;
  logic                 edge_det, win_last, clr;

  // Input sampling. Only the latency differs between the two builds; the
  // window and FSM timing are identical.
`ifdef FREQ_EST_SYNC_EN
  logic meta;
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      meta <= sig_in;
      s_q  <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) s_q <= 1'b0;
    else       s_q <= sig_in;
  end
`endif

  assign edge_det = s_q & ~s_d;
  assign win_last = (win_cnt == '1);
  // Saturate rather than wrap so an over-range count reads as all-ones.
  assign edge_nxt = (edge_det && edge_cnt != '1) ? edge_cnt + 1'b1 : edge_cnt;
  // Counters clear on every entry into MEASURE (from IDLE or from DONE).
  assign clr      = (state_nxt == MEASURE) && (state != MEASURE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MEASURE;
      MEASURE: begin
        if (abort)         state_nxt = IDLE;
        else if (win_last) state_nxt = DONE;
      end
      DONE:    if (ack) state_nxt = start ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s_d      <= 1'b0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      edges    <= '0;
      inc_est  <= '0;
    end else begin
      state <= state_nxt;
      // Previous sample tracks in every state, so a level that is already
      // high when the window opens is not seen as an edge.
      s_d   <= s_q;
      if (clr) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (state == MEASURE) begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_nxt;
      end
      // Results load only on a completed window; abort wins over completion.
      if (state == MEASURE && !abort && win_last) begin
        edges   <= edge_nxt;
        inc_est <= ACC_WIDTH'(edge_nxt) << SH;
      end
    end
  end

  assign busy  = (state == MEASURE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_freq_est.sv
// Directed bench for freq_est at ACC_WIDTH=24, GATE_LOG2=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_freq_est;

  localparam int ACC_WIDTH = 24;
  localparam int GATE_LOG2 = 8;

  logic                 clk = 1'b0;
  logic                 reset, sig_in, start, abort, ack;
  logic                 busy, valid;
  logic [GATE_LOG2-1:0] edges;
  logic [ACC_WIDTH-1:0] inc_est;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 0;   // 0: low, 1: period-16 square, 2: toggle, 3: high

  freq_est #(.ACC_WIDTH(ACC_WIDTH), .GATE_LOG2(GATE_LOG2)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start), .abort(abort),
    .ack(ack), .busy(busy), .valid(valid), .edges(edges), .inc_est(inc_est)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the next sig_in value follows the current mode.
  task automatic step();
    logic [31:0] c;
    @(negedge clk);
    cyc++;
    c = cyc;
    case (mode)
      1:       sig_in = c[3];
      2:       sig_in = c[0];
      3:       sig_in = 1'b1;
      default: sig_in = 1'b0;
    endcase
  endtask

  // Count clocks until valid rises, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int n;

  initial begin
    reset = 1'b1; sig_in = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_edges", 32'(edges), 0);
    chk("rst_inc", 32'(inc_est), 0);
    reset = 1'b0;
    step();

    // Period-16 square wave
    mode = 1; step(); step();
    start = 1'b1; step(); start = 1'b0; n = 1;
    chk("sq_busy", 32'(busy), 1);
    begin int m; wait_valid(m); n += m; end
    chk("sq_latency", 32'(n), 257);
    chk("sq_busy_done", 32'(busy), 0);
    chk("sq_edges", 32'(edges), 16);
    chk("sq_inc", 32'(inc_est), 32'h100000);

    // start without ack and abort are ignored in DONE
    pulse_start();
    chk("done_start_valid", 32'(valid), 1);
    chk("done_start_busy", 32'(busy), 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("done_abort_valid", 32'(valid), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_valid", 32'(valid), 0);
    chk("ack_busy", 32'(busy), 0);

    // Toggle every clock
    mode = 2; step();
    pulse_start();
    wait_valid(n);
    chk("tog_latency", 32'(n + 1), 257);
    chk("tog_edges", 32'(edges), 128);
    chk("tog_inc", 32'(inc_est), 32'h800000);
    ack = 1'b1; step(); ack = 1'b0;

    // Abort at cycle 100 of MEASURE; result of the toggle window retained
    mode = 1;
    pulse_start();
    repeat (99) step();
    chk("abort_busy_before", 32'(busy), 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 300; i++) begin
        step();
        if (valid) seen = 1;
      end
      chk("abort_no_valid", 32'(seen), 0);
    end
    chk("abort_edges", 32'(edges), 128);
    chk("abort_inc", 32'(inc_est), 32'h800000);

    // Level held high through start and window
    mode = 3; step(); step();
    pulse_start();
    wait_valid(n);
    chk("high_latency", 32'(n + 1), 257);
    chk("high_edges", 32'(edges), 0);
    chk("high_inc", 32'(inc_est), 0);

    // ack and start together in DONE restart directly
    mode = 1;
    ack = 1'b1; start = 1'b1; step(); ack = 1'b0; start = 1'b0;
    chk("ackst_busy", 32'(busy), 1);
    chk("ackst_valid", 32'(valid), 0);
    wait_valid(n);
    chk("ackst_latency", 32'(n + 1), 257);
    chk("ackst_edges", 32'(edges), 16);
    chk("ackst_inc", 32'(inc_est), 32'h100000);
    ack = 1'b1; step(); ack = 1'b0;

    // Reset mid-MEASURE clears everything, including held results
    pulse_start();
    repeat (50) step();
    reset = 1'b1; start = 1'b1; ack = 1'b1; step();
    reset = 1'b0; start = 1'b0; ack = 1'b0;
    chk("rstm_busy", 32'(busy), 0);
    chk("rstm_valid", 32'(valid), 0);
    chk("rstm_edges", 32'(edges), 0);
    chk("rstm_inc", 32'(inc_est), 0);

    // Reset in DONE
    mode = 2; step();
    pulse_start();
    wait_valid(n);
    chk("rstd_pre_edges", 32'(edges), 128);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstd_valid", 32'(valid), 0);
    chk("rstd_busy", 32'(busy), 0);
    chk("rstd_edges", 32'(edges), 0);
    chk("rstd_inc", 32'(inc_est), 0);

    // Fresh measurement after reset
    mode = 1; step();
    pulse_start();
    wait_valid(n);
    chk("post_latency", 32'(n + 1), 257);
    chk("post_edges", 32'(edges), 16);
    chk("post_inc", 32'(inc_est), 32'h100000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_est.md
FREQ_EST -- requirements
Module: freq_est

Interface
REQ-001 Parameter ACC_WIDTH, default 24, is the width of the phase-increment word estimated, matching the target NCO accumulator.
REQ-002 Parameter GATE_LOG2, default 8, sets the measurement window to 2^GATE_LOG2 clocks; legal range is 2..ACC_WIDTH.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 sig_in  input  1  is the periodic signal to measure, for example an NCO output MSB.
REQ-006 start  input  1  is a one-cycle request to begin a measurement.
REQ-007 abort  input  1  cancels an in-progress measurement.
REQ-008 ack  input  1  is the consumer acknowledge of a presented result.
REQ-009 busy  output  1  is high while a measurement window is open.
REQ-010 valid  output  1  is high while a result is held for the consumer.
REQ-011 edges  output  GATE_LOG2  is the rising-edge count of the last completed window.
REQ-012 inc_est  output  ACC_WIDTH  is the estimated phase increment of the last completed window.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, MEASURE and DONE.
REQ-014 The IDLE to MEASURE transition SHALL occur when start=1; edge counter and window counter SHALL clear on that transition.
REQ-015 MEASURE SHALL last exactly 2^GATE_LOG2 cycles, after which the FSM SHALL enter DONE; valid SHALL rise 2^GATE_LOG2+1 cycles after the start cycle.
REQ-016 A rising edge SHALL be counted in a MEASURE cycle when the internal sample s is 1 and its previous-cycle value is 0.
REQ-017 The previous-sample register SHALL update every cycle in all states, so a level already high at start is not counted.
REQ-018 The edge count SHALL be GATE_LOG2 bits wide and SHALL saturate at all-ones (2^GATE_LOG2-1), never wrap.
REQ-019 On entry to DONE, edges SHALL load the final count, and inc_est SHALL load edges shifted left by ACC_WIDTH-GATE_LOG2, zero-filled.
REQ-020 In DONE, valid SHALL be 1; edges and inc_est SHALL remain stable until the next DONE entry.
REQ-021 In DONE with ack=1, the FSM SHALL go to IDLE; with ack=1 and start=1 in the same cycle, it SHALL go directly to MEASURE.
REQ-022 start SHALL be ignored in MEASURE, and in DONE without ack.
REQ-023 In MEASURE, abort=1 SHALL return the FSM to IDLE with no valid pulse and edges/inc_est unchanged; abort has priority over window completion in the same cycle.
REQ-024 abort SHALL have no effect in IDLE or DONE.
REQ-025 busy SHALL equal (state==MEASURE) and valid SHALL equal (state==DONE), both driven from registers with no combinational input path.

Reset
REQ-026 reset=1 SHALL force IDLE, and clear busy, valid, edges, inc_est, all counters and the sample registers on the next rising edge, including mid-MEASURE and in DONE.
REQ-027 reset SHALL take priority over start, abort and ack.

Configuration
REQ-028 With macro FREQ_EST_SYNC_EN defined, s SHALL be sig_in passed through a two-flop synchronizer, adding 2 cycles of input latency, for asynchronous sig_in.
REQ-029 Without FREQ_EST_SYNC_EN, s SHALL be sig_in sampled directly with one register stage, and sig_in is required synchronous to clk.
REQ-030 With or without the macro, window length and all FSM timing SHALL be identical.

Verification (ACC_WIDTH=24, GATE_LOG2=8)
REQ-031 sig_in square wave of period 16, start pulse -> valid at cycle 257; edges=16; inc_est=0x100000.
REQ-032 sig_in toggling every clock -> edges=128; inc_est=0x800000.
REQ-033 sig_in held at 1 through start and the window -> edges=0; inc_est=0x000000.
REQ-034 abort at cycle 100 of MEASURE -> busy low next cycle; valid never asserts; prior edges/inc_est retained.
REQ-035 ack and start together in DONE -> busy=1 next cycle; valid=0; new window of 256 cycles completes.
REQ-036 reset asserted mid-MEASURE and mid-DONE -> all outputs 0 the following cycle; start afterwards behaves as after power-up.
